// File: rtl/audio_pkg.sv
// Shared types and sizing helpers for the serial audio transmit path.
package audio_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_t;

  localparam int unsigned UNDER_CNT_W = 16;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned num_ch,
                                             input int unsigned slot_w);
    return num_ch * slot_w;
  endfunction

endpackage

// File: rtl/audio_clk_div.sv
// Free-running divide-by-2*HALF clock generator with one-cycle rise/fall enables.
module audio_clk_div
  import audio_pkg::*;
#(
  parameter int unsigned HALF = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_clk,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = cnt_w(HALF);
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          w_term;

  assign w_term = (r_cnt == TERM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (w_term) begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Enables are high in the cycle whose closing edge toggles o_clk.
  assign o_clk  = r_clk;
  assign o_rise = w_term & ~r_clk;
  assign o_fall = w_term & r_clk;

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM serial transmitter with a one-frame shadow buffer,
// underrun replay, mute and a saturating underrun counter. Single clock domain.
module i2s_tdm_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned SLOT_W     = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MCLK_HALF  = 1,
  parameter int unsigned BCLK_HALF  = 16,
  parameter int unsigned UNDER_HOLD = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         mode_lj,
  input  logic                         mute,
  output logic                         dac_MCLK,
  output logic                         dac_SCLK,
  output logic                         dac_LRCK,
  output logic                         dac_SDIN,
  output logic                         frame_stb,
  output logic                         underrun,
  output logic [UNDER_CNT_W-1:0]       under_cnt
);

  localparam int unsigned FB = frame_bits(NUM_CH, SLOT_W);
  localparam int unsigned DW = NUM_CH * SAMPLE_W;
  localparam int unsigned BW = cnt_w(FB);
  localparam int unsigned IW = cnt_w(DW);
  localparam logic [BW-1:0] LAST = BW'(FB - 1);

  if (SLOT_W < SAMPLE_W || SAMPLE_W < 1 || SLOT_W < 1 || NUM_CH < 1 ||
      MCLK_HALF < 1 || BCLK_HALF < 1) begin : g_bad_param
    $error("i2s_tdm_tx: illegal parameter set");
  end

  logic w_mclk, w_mclk_rise, w_mclk_fall;
  logic w_bclk, w_bclk_rise, w_bclk_fall;
  logic w_unused_edges;

  audio_clk_div #(.HALF(MCLK_HALF)) u_mclk_div (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .o_clk   (w_mclk),
    .o_rise  (w_mclk_rise),
    .o_fall  (w_mclk_fall)
  );

  audio_clk_div #(.HALF(BCLK_HALF)) u_bclk_div (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .o_clk   (w_bclk),
    .o_rise  (w_bclk_rise),
    .o_fall  (w_bclk_fall)
  );

  assign w_unused_edges = ^{w_mclk_rise, w_mclk_fall, w_bclk_rise};

  logic [BW-1:0]          r_bit_cnt;
  logic [DW-1:0]          r_shift;
  logic [DW-1:0]          r_shadow;
  logic [DW-1:0]          r_prev;
  logic                   r_full;
  fmt_t                   r_fmt;
  logic                   r_sdin;
  logic                   r_lrck;
  logic                   r_frame_stb;
  logic                   r_underrun;
  logic [UNDER_CNT_W-1:0] r_under_cnt;

  logic                   w_load;
  logic                   w_xfer;
  logic [BW-1:0]          w_next_cnt;
  logic [DW-1:0]          w_next_shift;
  fmt_t                   w_next_fmt;
  logic                   w_lrck_next;
  logic                   w_sdin_next;

  function automatic logic f_raw(input logic [DW-1:0] frame, input logic [BW-1:0] cnt);
    int unsigned slot;
    int unsigned pos;
    logic [IW-1:0] idx;
    slot = 32'(cnt) / SLOT_W;
    pos  = 32'(cnt) % SLOT_W;
    idx  = IW'((NUM_CH - 1 - slot) * SAMPLE_W + (SAMPLE_W - 1 - pos));
    return (pos < SAMPLE_W) ? frame[idx] : 1'b0;
  endfunction

  assign w_load     = w_bclk_fall & (r_bit_cnt == LAST);
  assign w_xfer     = s_valid & ~r_full;
  assign w_next_cnt = (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_next_fmt = w_load ? (mode_lj ? FMT_LJ : FMT_I2S) : r_fmt;

  always_comb begin
    w_next_shift = r_shift;
    if (w_load) begin
      if (mute)                 w_next_shift = '0;
      else if (r_full)          w_next_shift = r_shadow;
      else if (UNDER_HOLD != 0) w_next_shift = r_prev;
      else                      w_next_shift = '0;
    end
  end

  always_comb begin
    w_lrck_next = 1'b0;
    if (NUM_CH == 2)
      w_lrck_next = (32'(w_next_cnt) >= SLOT_W) ^ (w_next_fmt == FMT_LJ);
    else if (w_next_fmt == FMT_LJ)
      w_lrck_next = (w_next_cnt == '0);
    else
      w_lrck_next = (w_next_cnt == LAST);
  end

  // Outputs are registered at the fall: LJ shows the bit being entered,
  // I2S shows the bit being left, giving the one-BCLK data delay.
  assign w_sdin_next = (w_next_fmt == FMT_LJ) ? f_raw(w_next_shift, w_next_cnt)
                                              : f_raw(r_shift, r_bit_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= LAST;
      r_shift     <= '0;
      r_shadow    <= '0;
      r_prev      <= '0;
      r_full      <= 1'b0;
      r_fmt       <= FMT_I2S;
      r_sdin      <= 1'b0;
      r_lrck      <= 1'b0;
      r_frame_stb <= 1'b0;
      r_underrun  <= 1'b0;
      r_under_cnt <= '0;
    end else begin
      r_frame_stb <= w_load;
      r_underrun  <= w_load & ~r_full;
      if (w_bclk_fall) begin
        r_bit_cnt <= w_next_cnt;
        r_shift   <= w_next_shift;
        r_fmt     <= w_next_fmt;
        r_sdin    <= w_sdin_next;
        r_lrck    <= w_lrck_next;
      end
      if (w_load && r_full)
        r_prev <= r_shadow;
      if (w_load && !r_full && (r_under_cnt != '1))
        r_under_cnt <= r_under_cnt + 1'b1;
      // A transfer in a load cycle only happens when the shadow was already
      // empty, so refilling it here never overwrites the frame being loaded.
      if (w_xfer) begin
        r_full   <= 1'b1;
        r_shadow <= s_data;
      end else if (w_load) begin
        r_full <= 1'b0;
      end
    end
  end

  assign s_ready   = ~r_full;
  assign dac_MCLK  = w_mclk;
  assign dac_SCLK  = w_bclk;
  assign dac_LRCK  = r_lrck;
  assign dac_SDIN  = r_sdin;
  assign frame_stb = r_frame_stb;
  assign underrun  = r_underrun;
  assign under_cnt = r_under_cnt;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Scoreboard bench: two transmitter configurations (2-ch I2S/LJ replaying, 4-slot TDM zero-fill).
module tb_i2s_tdm_tx;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int cfg, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %h, expected %h", cfg, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned NCH = (g == 0) ? 2  : 4;
    localparam int unsigned SW  = (g == 0) ? 16 : 24;
    localparam int unsigned SLW = (g == 0) ? 16 : 32;
    localparam int unsigned MH  = (g == 0) ? 1  : 3;
    localparam int unsigned BH  = (g == 0) ? 16 : 2;
    localparam int unsigned UH  = (g == 0) ? 1  : 0;
    localparam int unsigned FB  = NCH * SLW;
    localparam int unsigned DW  = NCH * SW;
    localparam int unsigned FP  = FB * 2 * BH;
    localparam logic [DW-1:0] FIXED = (g == 0) ? DW'(32'hA5A5_0F0F)
                                               : DW'(96'h800001_800002_800003_800004);

    logic          rst_n   = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          mode_lj = 1'b0;
    logic          mute    = 1'b0;
    logic          s_ready, dac_MCLK, dac_SCLK, dac_LRCK, dac_SDIN, frame_stb, underrun;
    logic [15:0]   under_cnt;
    bit            done = 1'b0;

    logic [DW-1:0] acc_q[$];
    int            acc_t[$];

    i2s_tdm_tx #(
      .SAMPLE_W   (SW),
      .SLOT_W     (SLW),
      .NUM_CH     (NCH),
      .MCLK_HALF  (MH),
      .BCLK_HALF  (BH),
      .UNDER_HOLD (UH)
    ) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .mode_lj   (mode_lj),
      .mute      (mute),
      .dac_MCLK  (dac_MCLK),
      .dac_SCLK  (dac_SCLK),
      .dac_LRCK  (dac_LRCK),
      .dac_SDIN  (dac_SDIN),
      .frame_stb (frame_stb),
      .underrun  (underrun),
      .under_cnt (under_cnt)
    );

    function automatic logic raw_bit(input logic [DW-1:0] f, input int b);
      int s;
      int p;
      logic [SW-1:0] sample;
      s = b / SLW;
      p = b % SLW;
      if (p >= SW) return 1'b0;
      sample = f[(NCH-1-s)*SW +: SW];
      return sample[SW-1-p];
    endfunction

    function automatic logic [DW-1:0] rnd();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
    endfunction

    task automatic send(input logic [DW-1:0] f);
      int n;
      n = 0;
      @(negedge clk);
      s_data  = f;
      s_valid = 1'b1;
      while (!s_ready && n < 4 * FP) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) begin
        checks++;
        errors++;
        $display("FAIL cfg%0d send_timeout: s_ready=%b after %0d cycles, required 1", g, s_ready, n);
      end else begin
        acc_q.push_back(f);
        acc_t.push_back(cyc + 1);
        @(negedge clk);
      end
      s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
      repeat (n * FP) @(negedge clk);
    endtask

    task automatic check_reset_outs();
      chk(g, "rst_s_ready", 128'(s_ready), 128'(1));
      chk(g, "rst_mclk", 128'(dac_MCLK), 128'(0));
      chk(g, "rst_sclk", 128'(dac_SCLK), 128'(0));
      chk(g, "rst_lrck", 128'(dac_LRCK), 128'(0));
      chk(g, "rst_sdin", 128'(dac_SDIN), 128'(0));
      chk(g, "rst_frame_stb", 128'(frame_stb), 128'(0));
      chk(g, "rst_underrun", 128'(underrun), 128'(0));
      chk(g, "rst_under_cnt", 128'(under_cnt), 128'(0));
    endtask

    initial begin : mon
      logic          sclk_q, mclk_q, last_raw, exp_stb, exp_under, lj;
      int            last_rise, last_mtog, fcnt, bidx, ucnt_m;
      logic [FB-1:0] act_sd, act_lr, exp_sd, exp_lr;
      logic [DW-1:0] prev_m, sent;
      sclk_q = 1'b0; mclk_q = 1'b0; last_raw = 1'b0;
      last_rise = -1; last_mtog = -1; fcnt = FB - 1; bidx = -1; ucnt_m = 0;
      act_sd = '0; act_lr = '0; exp_sd = '0; exp_lr = '0; prev_m = '0; sent = '0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
          sclk_q = 1'b0; mclk_q = 1'b0; last_raw = 1'b0;
          last_rise = -1; last_mtog = -1; fcnt = FB - 1; bidx = -1; ucnt_m = 0;
          prev_m = '0;
          continue;
        end
        if (dac_MCLK != mclk_q) begin
          if (last_mtog >= 0) chk(g, "mclk_half_period", 128'(cyc - last_mtog), 128'(MH));
          last_mtog = cyc;
        end
        mclk_q = dac_MCLK;
        if (dac_SCLK && !sclk_q) begin
          if (last_rise >= 0) chk(g, "sclk_period", 128'(cyc - last_rise), 128'(2 * BH));
          last_rise = cyc;
          if (bidx >= 0 && bidx < FB) begin
            act_sd[FB-1-bidx] = dac_SDIN;
            act_lr[FB-1-bidx] = dac_LRCK;
            bidx++;
            if (bidx == FB) begin
              chk(g, "sdin_frame", 128'(act_sd), 128'(exp_sd));
              chk(g, "lrck_frame", 128'(act_lr), 128'(exp_lr));
            end
          end
        end
        if (!dac_SCLK && sclk_q) begin
          exp_stb = (fcnt == FB - 1);
          chk(g, "stb_on_wrap_fall", 128'(frame_stb), 128'(exp_stb));
          fcnt = exp_stb ? 0 : fcnt + 1;
        end else if (frame_stb) begin
          chk(g, "stb_without_fall", 128'(frame_stb), 128'(0));
        end
        sclk_q = dac_SCLK;
        if (!frame_stb) chk(g, "underrun_idle", 128'(underrun), 128'(0));
        if (frame_stb) begin
          if (bidx >= 0 && bidx != FB) chk(g, "frame_len", 128'(bidx), 128'(FB));
          if (acc_q.size() > 0 && acc_t[0] < cyc) begin
            sent = acc_q.pop_front();
            void'(acc_t.pop_front());
            prev_m = sent;
            exp_under = 1'b0;
          end else begin
            sent = (UH != 0) ? prev_m : '0;
            exp_under = 1'b1;
            if (ucnt_m < 65535) ucnt_m++;
          end
          if (mute) sent = '0;
          chk(g, "underrun", 128'(underrun), 128'(exp_under));
          chk(g, "under_cnt", 128'(under_cnt), 128'(ucnt_m));
          lj = mode_lj;
          for (int b = 0; b < FB; b++) begin
            if (lj)          exp_sd[FB-1-b] = raw_bit(sent, b);
            else if (b == 0) exp_sd[FB-1-b] = last_raw;
            else             exp_sd[FB-1-b] = raw_bit(sent, b - 1);
            if (NCH == 2) exp_lr[FB-1-b] = lj ? (b < SLW) : (b >= SLW);
            else          exp_lr[FB-1-b] = lj ? (b == 0) : (b == FB - 1);
          end
          last_raw = raw_bit(sent, FB - 1);
          bidx = 0;
        end
      end
    end

    initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      #1 check_reset_outs();
      @(negedge clk);
      rst_n = 1'b1;
      // straight I2S traffic, fixed then random
      repeat (3) send(FIXED);
      repeat (4) send(rnd());
      // starve the shadow for several frames
      send(rnd());
      wait_frames(4);
      // left-justified, switched mid-frame
      repeat ($urandom_range(FP - 1, 1)) @(negedge clk);
      mode_lj = 1'b1;
      send(FIXED);
      repeat (3) send(rnd());
      // mute raised mid-frame, frames still consumed
      repeat ($urandom_range(FP - 1, 1)) @(negedge clk);
      mute = 1'b1;
      repeat (3) send(rnd());
      mute = 1'b0;
      repeat (2) send(rnd());
      mode_lj = 1'b0;
      wait_frames(2);
      // transfer landing exactly on a load edge
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!frame_stb && n < 2 * FP);
      chk(g, "load_seen", 128'(frame_stb), 128'(1));
      repeat (FP - 1) @(posedge clk);
      @(negedge clk);
      chk(g, "ready_before_load_xfer", 128'(s_ready), 128'(1));
      s_data  = rnd();
      s_valid = 1'b1;
      acc_q.push_back(s_data);
      acc_t.push_back(cyc + 1);
      @(negedge clk);
      s_valid = 1'b0;
      chk(g, "shadow_full_after_load_xfer", 128'(s_ready), 128'(0));
      repeat (2) send(rnd());
      // reset mid-frame with a frame pending in the shadow
      send(rnd());
      send(rnd());
      repeat ($urandom_range(FP / 4, 1)) @(negedge clk);
      rst_n = 1'b0;
      acc_q.delete();
      acc_t.delete();
      #1 check_reset_outs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_frames(1);
      repeat (3) send(rnd());
      wait_frames(2);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_cfg[0].done && g_cfg[1].done);
      begin
        repeat (95000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL global_timeout: done=%b%b, required 11", g_cfg[0].done, g_cfg[1].done);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
